cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the rv32i core's instruction-fetch port and its load/store port.
- Arbitrates requests, sequences the RAM control signals and routes read data back to the owning port.
- At most one access is in flight at a time.
- Sits between the core and the unified program/data memory in the SoC top level.

Parameters:
- ADDR_WIDTH, 16: word-address width on all ports.
- RD_LATENCY, 1: cycles from RAM command to valid mem_rdata. Legal range 1..4.
- STARVE_LIMIT, 4: consecutive cycles a pending fetch may lose to data before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- i_req  in  1  fetch request (read only).
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_wmask  in  4  byte-lane write mask.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data.
- mem_en  out  1  RAM command strobe.
- mem_we  out  1  RAM write enable.
- mem_wmask  out  4  RAM byte mask.
- mem_addr  out  ADDR_WIDTH  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid RD_LATENCY cycles after the command.

Behaviour:
- FSM states:
  - IDLE: can grant.
  - RD_WAIT: a read is outstanding.
- Grant rules:
  - Grant is combinational from the req inputs and state. At most one of i_gnt/d_gnt is high per cycle, and only in IDLE or in the final RD_WAIT cycle (see back-to-back).
  - In the grant cycle, mem_en=1 and mem_addr/mem_we/mem_wmask/mem_wdata come from the winner.
  - A fetch always drives mem_we=0 and mem_wmask=0.
- Priority:
  - Data beats fetch.
  - Exception: when starve_cnt == STARVE_LIMIT and i_req is high, the fetch wins.
- Starvation counter (starve_cnt, 4 bit):
  - Increments each cycle i_req is high without i_gnt, saturating at STARVE_LIMIT.
  - Clears on i_gnt, or when i_req is low.
- Store grant:
  - Completes in the grant cycle; no rvalid is issued.
  - The FSM stays in IDLE, so back-to-back stores and store-then-read are granted on consecutive cycles.
- Read grant:
  - Latch owner (fetch/data) and load rd_cnt = RD_LATENCY; go to RD_WAIT.
  - rd_cnt decrements each cycle.
  - In the cycle rd_cnt == 1 (i.e. RD_LATENCY cycles after the grant), raise the owner's rvalid for exactly one cycle with rdata = mem_rdata passthrough.
  - The non-owner's rvalid stays 0; both rdata buses carry mem_rdata.
- Back-to-back: in the rvalid cycle the arbiter behaves as IDLE and may grant a new request. Next state is RD_WAIT if that grant is a read, else IDLE. Sustained read throughput is therefore one read per RD_LATENCY cycles.
- While in RD_WAIT before the final cycle: i_gnt = d_gnt = 0 and mem_en = 0. Requesters hold req, address and data stable until gnt.
- Simultaneous i_req and d_req are resolved by the priority rules; the loser sees no gnt and retries implicitly.
- Reset (reset_n = 0 at a clock edge):
  - Takes priority over all other activity.
  - State goes to IDLE; rd_cnt, owner and starve_cnt clear to 0.
  - Outputs: all gnt/rvalid = 0, mem_en = 0, mem_we = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0.
  - A read in flight at reset is dropped; no rvalid is ever issued for it.
- Idle outputs: mem_* outputs are 0 whenever mem_en = 0.

Optional Feature:
- Macro: CPU_MEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_i_stall[31:0], perf_d_stall[31:0] and perf_rd_cnt[31:0].
  - perf_i_stall / perf_d_stall count cycles with req high and no gnt on that port.
  - perf_rd_cnt counts read grants.
  - All three are wrapping counters, cleared by reset.
- When undefined: these ports and counters do not exist, and grant and rvalid behaviour is identical.

Decomposition:
- Shared package:
  - State encoding localparams ARB_IDLE = 0, ARB_RD_WAIT = 1.
  - Owner encoding OWN_I = 0, OWN_D = 1.
- Sub-module: cpu_mem_arb_starve, holding the saturating starvation counter and its force-fetch flag. Everything else stays in the top module.

Test Plan:
- Fetch read: i_req at addr 0x0010, mem returns 0xDEADBEEF, RD_LATENCY = 1 -> i_gnt in cycle T; i_rvalid = 1 with i_rdata = 0xDEADBEEF in T+1; d_rvalid = 0.
- Collision: i_req and d_req (load, addr 0x0020) raised together -> d_gnt first; i_gnt in the d_rvalid cycle; i_rvalid one cycle later.
- Starvation: d_req stores held continuously, i_req held, STARVE_LIMIT = 4 -> exactly 4 cycles of d_gnt, then i_gnt on the 5th cycle; data resumes afterwards.
- Stores: two stores with wmask 4'b0011 then 4'b1100 -> d_gnt on consecutive cycles; mem_we = 1 with matching masks; no d_rvalid.
- Latency: RD_LATENCY = 3, data load -> no gnt in T+1 and T+2; d_rvalid only in T+3.
- Reset mid-read: reset_n low at T+1 of an RD_LATENCY = 3 load -> no d_rvalid ever; outputs 0; a new i_req is granted in the first cycle after reset_n goes high.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// ============================================================================
// Module      : cpu_mem_arbiter_pkg
// Description : Shared encodings for the fetch/load-store RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_arbiter_pkg;

  localparam logic ARB_IDLE    = 1'b0;
  localparam logic ARB_RD_WAIT = 1'b1;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // rd_cnt must hold RD_LATENCY up to 4; starve_cnt holds STARVE_LIMIT up to 15
  localparam int c_RD_CNT_W = 3;
  localparam int c_STARVE_W = 4;

  typedef enum logic {
    ST_IDLE    = ARB_IDLE,
    ST_RD_WAIT = ARB_RD_WAIT
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_mem_arb_starve.sv
// ============================================================================
// Module      : cpu_mem_arb_starve
// Description : Saturating count of cycles a pending fetch lost arbitration,
//               flagging when the fetch must be forced to win.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mem_arb_starve
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force_fetch
);

  logic [c_STARVE_W-1:0] r_cnt_q;
  logic [c_STARVE_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt_q;
    if (!i_req || i_gnt) begin
      w_cnt_d = '0;
    end else if (r_cnt_q != c_STARVE_W'(STARVE_LIMIT)) begin
      w_cnt_d = r_cnt_q + c_STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt_q <= '0;
    end else begin
      r_cnt_q <= w_cnt_d;
    end
  end

  assign o_force_fetch = i_req && (r_cnt_q == c_STARVE_W'(STARVE_LIMIT));

endmodule

`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Shares one single-port synchronous RAM between the core's
//               fetch and load/store ports, one access in flight at a time.
//               Define CPU_MEM_ARB_PERF_EN to add stall/read perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_wmask,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
`ifdef CPU_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_i_stall,
  output logic [31:0]           perf_d_stall,
  output logic [31:0]           perf_rd_cnt
`endif
);

  arb_state_e            r_state_q, w_state_d;
  logic [c_RD_CNT_W-1:0] r_rd_cnt_q, w_rd_cnt_d;
  logic                  r_owner_q, w_owner_d;

  logic w_force_fetch;
  logic w_final;
  logic w_can_grant;
  logic w_i_win;
  logic w_d_win;
  logic w_rd_grant;

  cpu_mem_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req         (i_req),
    .i_gnt         (i_gnt),
    .o_force_fetch (w_force_fetch)
  );

  // The last RD_WAIT cycle doubles as an idle cycle so reads can issue back-to-back
  assign w_final     = reset_n && (r_state_q == ST_RD_WAIT) && (r_rd_cnt_q == c_RD_CNT_W'(1));
  assign w_can_grant = reset_n && ((r_state_q == ST_IDLE) || w_final);
  assign w_i_win     = w_can_grant && i_req && (!d_req || w_force_fetch);
  assign w_d_win     = w_can_grant && d_req && !w_force_fetch;
  assign w_rd_grant  = w_i_win || (w_d_win && !d_we);

  always_comb begin
    w_state_d  = r_state_q;
    w_rd_cnt_d = r_rd_cnt_q;
    w_owner_d  = r_owner_q;
    if (r_state_q == ST_RD_WAIT) begin
      w_rd_cnt_d = r_rd_cnt_q - c_RD_CNT_W'(1);
      if (w_final) begin
        w_state_d = ST_IDLE;
      end
    end
    if (w_rd_grant) begin
      w_state_d  = ST_RD_WAIT;
      w_rd_cnt_d = c_RD_CNT_W'(RD_LATENCY);
      w_owner_d  = w_i_win ? OWN_I : OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state_q  <= ST_IDLE;
      r_rd_cnt_q <= '0;
      r_owner_q  <= OWN_I;
    end else begin
      r_state_q  <= w_state_d;
      r_rd_cnt_q <= w_rd_cnt_d;
      r_owner_q  <= w_owner_d;
    end
  end

  assign i_gnt     = w_i_win;
  assign d_gnt     = w_d_win;
  assign mem_en    = w_i_win || w_d_win;
  assign mem_we    = w_d_win && d_we;
  assign mem_wmask = w_d_win ? d_wmask : 4'b0000;
  assign mem_wdata = w_d_win ? d_wdata : 32'h0;
  assign mem_addr  = w_i_win ? i_addr : (w_d_win ? d_addr : '0);

  assign i_rvalid = w_final && (r_owner_q == OWN_I);
  assign d_rvalid = w_final && (r_owner_q == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

`ifdef CPU_MEM_ARB_PERF_EN
  logic [31:0] r_perf_i_q, w_perf_i_d;
  logic [31:0] r_perf_d_q, w_perf_d_d;
  logic [31:0] r_perf_rd_q, w_perf_rd_d;

  always_comb begin
    w_perf_i_d  = r_perf_i_q  + ((i_req && !i_gnt) ? 32'd1 : 32'd0);
    w_perf_d_d  = r_perf_d_q  + ((d_req && !d_gnt) ? 32'd1 : 32'd0);
    w_perf_rd_d = r_perf_rd_q + (w_rd_grant ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_i_q  <= '0;
      r_perf_d_q  <= '0;
      r_perf_rd_q <= '0;
    end else begin
      r_perf_i_q  <= w_perf_i_d;
      r_perf_d_q  <= w_perf_d_d;
      r_perf_rd_q <= w_perf_rd_d;
    end
  end

  assign perf_i_stall = r_perf_i_q;
  assign perf_d_stall = r_perf_d_q;
  assign perf_rd_cnt  = r_perf_rd_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
// ============================================================================
// Module      : tb_cpu_mem_arbiter
// Description : Scoreboard bench; instance a uses RD_LATENCY=1, b uses 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // instance a: RD_LATENCY = 1
  logic        a_i_req, a_i_gnt, a_i_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic        a_mem_en, a_mem_we;
  logic [3:0]  a_d_wmask, a_mem_wmask;
  logic [15:0] a_i_addr, a_d_addr, a_mem_addr;
  logic [31:0] a_i_rdata, a_d_rdata, a_d_wdata, a_mem_wdata, a_mem_rdata;
  // instance b: RD_LATENCY = 3
  logic        b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic        b_mem_en, b_mem_we;
  logic [3:0]  b_d_wmask, b_mem_wmask;
  logic [15:0] b_i_addr, b_d_addr, b_mem_addr;
  logic [31:0] b_i_rdata, b_d_rdata, b_d_wdata, b_mem_wdata, b_mem_rdata;

  cpu_mem_arbiter #(.ADDR_WIDTH(16), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_wmask(a_d_wmask), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_wmask(a_mem_wmask), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  cpu_mem_arbiter #(.ADDR_WIDTH(16), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_wmask(b_d_wmask), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_wmask(b_mem_wmask), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // RAM models, preloaded with known words while reset is low
  logic [31:0] a_ram [0:255];
  logic [31:0] a_p0;
  logic [31:0] b_ram [0:255];
  logic [31:0] b_p0, b_p1, b_p2;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) a_ram[i] <= 32'h0;
      a_ram[8'h10] <= 32'hDEADBEEF;
      a_ram[8'h20] <= 32'h12345678;
      a_ram[8'h30] <= 32'hCAFEF00D;
    end else if (a_mem_en) begin
      if (a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_wmask[k]) a_ram[a_mem_addr[7:0]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end else begin
        a_p0 <= a_ram[a_mem_addr[7:0]];
      end
    end
  end
  assign a_mem_rdata = a_p0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) b_ram[i] <= 32'h0;
      b_ram[8'h60] <= 32'h0BADF00D;
      b_ram[8'h61] <= 32'h61616161;
    end
    b_p0 <= (b_mem_en && !b_mem_we) ? b_ram[b_mem_addr[7:0]] : 32'h0;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct { bit port; logic [31:0] data; } exp_t;  // port: 0 fetch, 1 data
  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;

  always @(negedge clk) begin
    if (a_i_rvalid || a_d_rvalid) begin
      if (a_q.size() == 0) begin
        chk("a_unexpected_rvalid", 32'({a_i_rvalid, a_d_rvalid}), 32'd0);
      end else begin
        a_e = a_q.pop_front();
        chk("a_rvalid_port", 32'({a_i_rvalid, a_d_rvalid}), a_e.port ? 32'd1 : 32'd2);
        chk("a_i_rdata", a_i_rdata, a_e.data);
        chk("a_d_rdata", a_d_rdata, a_e.data);
      end
    end
    if (b_i_rvalid || b_d_rvalid) begin
      if (b_q.size() == 0) begin
        chk("b_unexpected_rvalid", 32'({b_i_rvalid, b_d_rvalid}), 32'd0);
      end else begin
        b_e = b_q.pop_front();
        chk("b_rvalid_port", 32'({b_i_rvalid, b_d_rvalid}), b_e.port ? 32'd1 : 32'd2);
        chk("b_rdata", b_e.port ? b_d_rdata : b_i_rdata, b_e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    {a_i_req, a_d_req, a_d_we, b_i_req, b_d_req, b_d_we} = '0;
    {a_d_wmask, b_d_wmask} = '0;
    {a_i_addr, a_d_addr, b_i_addr, b_d_addr} = '0;
    {a_d_wdata, b_d_wdata} = '0;
    repeat (3) cyc();
    #3;
    chk("rst_a_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_b_mem_en", 32'(b_mem_en), 32'd0);

    cyc(); reset_n = 1'b1; #3;
    chk("rst_a_ctrl", 32'({a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_mem_en, a_mem_we, a_mem_wmask}), 32'd0);
    chk("rst_a_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_a_wdata", a_mem_wdata, 32'd0);

    // fetch read, latency 1
    cyc(); a_i_req = 1'b1; a_i_addr = 16'h0010; a_q.push_back('{1'b0, 32'hDEADBEEF}); #3;
    chk("fetch_i_gnt", 32'({a_i_gnt, a_d_gnt}), 32'd2);
    chk("fetch_mem_addr", 32'(a_mem_addr), 32'h10);
    chk("fetch_mem_we_mask", 32'({a_mem_en, a_mem_we, a_mem_wmask}), 32'h20);
    cyc(); a_i_req = 1'b0; #3;
    chk("fetch_i_rvalid", 32'({a_i_rvalid, a_d_rvalid}), 32'd2);
    chk("fetch_i_rdata", a_i_rdata, 32'hDEADBEEF);

    // collision: data load first, fetch granted in the d_rvalid cycle
    cyc(); a_i_req = 1'b1; a_i_addr = 16'h0010;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0020;
    a_q.push_back('{1'b1, 32'h12345678}); a_q.push_back('{1'b0, 32'hDEADBEEF}); #3;
    chk("coll_d_first", 32'({a_i_gnt, a_d_gnt}), 32'd1);
    cyc(); a_d_req = 1'b0; #3;
    chk("coll_i_gnt_b2b", 32'({a_i_gnt, a_d_rvalid}), 32'd3);
    cyc(); a_i_req = 1'b0; #3;
    chk("coll_i_rvalid", 32'({a_i_gnt, a_i_rvalid}), 32'd1);

    // starvation: held stores, fetch forced on the 5th cycle
    cyc(); a_d_req = 1'b1; a_d_we = 1'b1; a_d_wmask = 4'hF; a_d_addr = 16'h0050; a_d_wdata = 32'h55555555;
    a_i_req = 1'b1; a_i_addr = 16'h0030; a_q.push_back('{1'b0, 32'hCAFEF00D});
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) cyc();
      #3;
      chk($sformatf("starve_cycle%0d", k), 32'({a_i_gnt, a_d_gnt}), (k == 5) ? 32'd2 : 32'd1);
    end
    cyc(); a_i_req = 1'b0; #3;
    chk("starve_data_resumes", 32'({a_i_gnt, a_d_gnt, a_i_rvalid}), 32'd3);
    cyc(); a_d_req = 1'b0; #3;

    // masked stores back-to-back, then a load of the merged word
    cyc(); a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 16'h0040; a_d_wmask = 4'b0011; a_d_wdata = 32'hAABBCCDD; #3;
    chk("st1_gnt_we", 32'({a_d_gnt, a_mem_we}), 32'd3);
    chk("st1_mask", 32'(a_mem_wmask), 32'h3);
    chk("st1_wdata", a_mem_wdata, 32'hAABBCCDD);
    cyc(); a_d_wmask = 4'b1100; a_d_wdata = 32'h11223344; #3;
    chk("st2_gnt_we", 32'({a_d_gnt, a_mem_we, a_d_rvalid}), 32'd6);
    chk("st2_mask", 32'(a_mem_wmask), 32'hC);
    cyc(); a_d_we = 1'b0; a_d_wmask = 4'b0000; a_q.push_back('{1'b1, 32'h1122CCDD}); #3;
    chk("st_then_ld_gnt", 32'({a_d_gnt, a_mem_we, a_d_rvalid}), 32'd4);
    cyc(); a_d_req = 1'b0; #3;
    chk("ld_merged_rvalid", 32'(a_d_rvalid), 32'd1);

    // latency 3 load on instance b, fetch waits then issues back-to-back
    cyc(); b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 16'h0060; b_q.push_back('{1'b1, 32'h0BADF00D}); #3;
    chk("lat3_d_gnt", 32'(b_d_gnt), 32'd1);
    cyc(); b_d_req = 1'b0; b_i_req = 1'b1; b_i_addr = 16'h0061; b_q.push_back('{1'b0, 32'h61616161}); #3;
    chk("lat3_t1_quiet", 32'({b_i_gnt, b_d_gnt, b_mem_en, b_d_rvalid}), 32'd0);
    cyc(); #3;
    chk("lat3_t2_quiet", 32'({b_i_gnt, b_d_gnt, b_mem_en, b_d_rvalid}), 32'd0);
    cyc(); #3;
    chk("lat3_t3_rvalid_gnt", 32'({b_d_rvalid, b_i_gnt}), 32'd3);
    cyc(); b_i_req = 1'b0; #3;
    chk("lat3_i_not_yet", 32'(b_i_rvalid), 32'd0);
    cyc(); cyc(); #3;
    chk("lat3_i_rvalid", 32'(b_i_rvalid), 32'd1);

    // reset during a latency-3 load: the read is dropped
    cyc(); b_d_req = 1'b1; b_d_addr = 16'h0060; #3;
    chk("rstrd_d_gnt", 32'(b_d_gnt), 32'd1);
    cyc(); b_d_req = 1'b0; reset_n = 1'b0; #3;
    chk("rstrd_quiet1", 32'({b_d_gnt, b_mem_en, b_d_rvalid}), 32'd0);
    cyc(); #3;
    chk("rstrd_quiet2", 32'({b_d_rvalid, b_i_rvalid, b_mem_en}), 32'd0);
    chk("rstrd_addr", 32'(b_mem_addr), 32'd0);
    cyc(); reset_n = 1'b1; b_i_req = 1'b1; b_i_addr = 16'h0061; b_q.push_back('{1'b0, 32'h61616161}); #3;
    chk("rstrd_new_i_gnt", 32'({b_i_gnt, b_d_rvalid}), 32'd2);
    cyc(); b_i_req = 1'b0; cyc(); cyc(); #3;
    chk("rstrd_i_rvalid", 32'(b_i_rvalid), 32'd1);

    repeat (6) cyc();
    chk("a_queue_drained", 32'(a_q.size()), 32'd0);
    chk("b_queue_drained", 32'(b_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
